// File: rtl/register_read_stage.sv
// Register-read stage: busy-scoreboard hazard check, operand read with same-cycle
// writeback bypass, and a one-entry output register feeding address calculation.
module register_read_stage #(
  parameter int  NUM_REGS = 16,
  parameter int  DATA_W   = 64,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              decodeValidIn,
  input  logic [7:0]        opcodeIn,
  input  logic [IDX_W-1:0]  sourceReg1In,
  input  logic [IDX_W-1:0]  sourceReg2In,
  input  logic              sourceReg1ValidIn,
  input  logic              sourceReg2ValidIn,
  input  logic [IDX_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  output logic              stallOut,
  input  logic              wbValidIn,
  input  logic [IDX_W-1:0]  wbRegIn,
  input  logic [DATA_W-1:0] wbDataIn,
  input  logic              readyIn,
  output logic              opcodeValidOut,
  output logic [7:0]        opcodeOut,
  output logic [IDX_W-1:0]  sourceRegCode1Out,
  output logic [IDX_W-1:0]  sourceRegCode2Out,
  output logic              sourceRegCode1ValidOut,
  output logic              sourceRegCode2ValidOut,
  output logic [DATA_W-1:0] operand1ValOut,
  output logic [DATA_W-1:0] operand2ValOut,
  output logic              operand1ValValidOut,
  output logic              operand2ValValidOut,
  output logic [IDX_W-1:0]  destRegOut,
  output logic              destRegValidOut
);

  logic [DATA_W-1:0]   regfile [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;
  logic                wbHit1, wbHit2;
  logic                hazard1, hazard2;
  logic                outBlocked;
  logic                accept;
  logic [DATA_W-1:0]   operand1, operand2;

  // Handshake: the output register transfers downstream on every edge where
  // opcodeValidOut && readyIn; decode transfers in on every edge where
  // decodeValidIn && !stallOut. A transfer out and in on the same edge has no bubble.
  always_comb begin
    wbHit1     = wbValidIn && (wbRegIn == sourceReg1In);
    wbHit2     = wbValidIn && (wbRegIn == sourceReg2In);
    hazard1    = sourceReg1ValidIn && busy[sourceReg1In] && !wbHit1;
    hazard2    = sourceReg2ValidIn && busy[sourceReg2In] && !wbHit2;
    outBlocked = opcodeValidOut && !readyIn;
    stallOut   = decodeValidIn && (hazard1 || hazard2 || outBlocked);
    accept     = decodeValidIn && !stallOut;

    operand1 = '0;
    if (sourceReg1ValidIn) operand1 = wbHit1 ? wbDataIn : regfile[sourceReg1In];
    operand2 = '0;
    if (sourceReg2ValidIn) operand2 = wbHit2 ? wbDataIn : regfile[sourceReg2In];

    // Set after clear: a new producer claiming a register outranks a retiring one.
    busyNext = busy;
    if (wbValidIn) busyNext[wbRegIn] = 1'b0;
    if (accept && destRegValidIn) busyNext[destRegIn] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
      busy                   <= '0;
      opcodeValidOut         <= 1'b0;
      opcodeOut              <= '0;
      sourceRegCode1Out      <= '0;
      sourceRegCode2Out      <= '0;
      sourceRegCode1ValidOut <= 1'b0;
      sourceRegCode2ValidOut <= 1'b0;
      operand1ValOut         <= '0;
      operand2ValOut         <= '0;
      operand1ValValidOut    <= 1'b0;
      operand2ValValidOut    <= 1'b0;
      destRegOut             <= '0;
      destRegValidOut        <= 1'b0;
    end else begin
      if (wbValidIn) regfile[wbRegIn] <= wbDataIn;
      busy <= busyNext;
      if (accept) begin
        opcodeValidOut         <= 1'b1;
        opcodeOut              <= opcodeIn;
        sourceRegCode1Out      <= sourceReg1In;
        sourceRegCode2Out      <= sourceReg2In;
        sourceRegCode1ValidOut <= sourceReg1ValidIn;
        sourceRegCode2ValidOut <= sourceReg2ValidIn;
        operand1ValOut         <= operand1;
        operand2ValOut         <= operand2;
        operand1ValValidOut    <= sourceReg1ValidIn;
        operand2ValValidOut    <= sourceReg2ValidIn;
        destRegOut             <= destRegIn;
        destRegValidOut        <= destRegValidIn;
      end else if (readyIn) begin
        opcodeValidOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_read_stage.sv
// Bench for register_read_stage: directed scenarios plus random traffic, with a
// reference model feeding an expected queue that a negedge monitor drains.
module tb_register_read_stage;
  localparam int W = 153;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        decodeValidIn;
  logic [7:0]  opcodeIn;
  logic [3:0]  sourceReg1In, sourceReg2In;
  logic        sourceReg1ValidIn, sourceReg2ValidIn;
  logic [3:0]  destRegIn;
  logic        destRegValidIn;
  logic        stallOut;
  logic        wbValidIn;
  logic [3:0]  wbRegIn;
  logic [63:0] wbDataIn;
  logic        readyIn;
  logic        opcodeValidOut;
  logic [7:0]  opcodeOut;
  logic [3:0]  sourceRegCode1Out, sourceRegCode2Out;
  logic        sourceRegCode1ValidOut, sourceRegCode2ValidOut;
  logic [63:0] operand1ValOut, operand2ValOut;
  logic        operand1ValValidOut, operand2ValValidOut;
  logic [3:0]  destRegOut;
  logic        destRegValidOut;

  register_read_stage dut (
    .clk(clk), .reset(reset),
    .decodeValidIn(decodeValidIn), .opcodeIn(opcodeIn),
    .sourceReg1In(sourceReg1In), .sourceReg2In(sourceReg2In),
    .sourceReg1ValidIn(sourceReg1ValidIn), .sourceReg2ValidIn(sourceReg2ValidIn),
    .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
    .stallOut(stallOut),
    .wbValidIn(wbValidIn), .wbRegIn(wbRegIn), .wbDataIn(wbDataIn),
    .readyIn(readyIn),
    .opcodeValidOut(opcodeValidOut), .opcodeOut(opcodeOut),
    .sourceRegCode1Out(sourceRegCode1Out), .sourceRegCode2Out(sourceRegCode2Out),
    .sourceRegCode1ValidOut(sourceRegCode1ValidOut), .sourceRegCode2ValidOut(sourceRegCode2ValidOut),
    .operand1ValOut(operand1ValOut), .operand2ValOut(operand2ValOut),
    .operand1ValValidOut(operand1ValValidOut), .operand2ValValidOut(operand2ValValidOut),
    .destRegOut(destRegOut), .destRegValidOut(destRegValidOut)
  );

  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic [63:0]  ref_regs [16];
  logic [15:0]  ref_busy;
  logic         ref_out_valid;
  logic         last_stall;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] out_vec();
    return {opcodeOut, sourceRegCode1Out, sourceRegCode1ValidOut, operand1ValOut, operand1ValValidOut,
            sourceRegCode2Out, sourceRegCode2ValidOut, operand2ValOut, operand2ValValidOut,
            destRegOut, destRegValidOut};
  endfunction

  // Operand seen by an instruction: unused -> 0, writeback this cycle -> that data, else the file.
  function automatic logic [63:0] ref_operand(input logic [3:0] s, input logic used);
    if (!used) return 64'd0;
    if (wbValidIn && wbRegIn == s) return wbDataIn;
    return ref_regs[s];
  endfunction

  function automatic logic src_blocked(input logic [3:0] s, input logic used);
    return used && ref_busy[s] && !(wbValidIn && wbRegIn == s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_regs[i] = 64'd0;
    ref_busy      = 16'd0;
    ref_out_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle();
    reset = 1'b0; decodeValidIn = 1'b0; opcodeIn = 8'd0;
    sourceReg1In = 4'd0; sourceReg2In = 4'd0; sourceReg1ValidIn = 1'b0; sourceReg2ValidIn = 1'b0;
    destRegIn = 4'd0; destRegValidIn = 1'b0;
    wbValidIn = 1'b0; wbRegIn = 4'd0; wbDataIn = 64'd0; readyIn = 1'b1;
  endtask

  task automatic issue(input logic [7:0] opc, input logic [3:0] s1, input logic v1,
                       input logic [3:0] s2, input logic v2, input logic [3:0] d, input logic dv);
    decodeValidIn = 1'b1; opcodeIn = opc;
    sourceReg1In = s1; sourceReg1ValidIn = v1; sourceReg2In = s2; sourceReg2ValidIn = v2;
    destRegIn = d; destRegValidIn = dv;
  endtask

  task automatic wb(input logic [3:0] r, input logic [63:0] data);
    wbValidIn = 1'b1; wbRegIn = r; wbDataIn = data;
  endtask

  // One clock: check combinational stall and output-valid mid-cycle, then advance the model.
  task automatic step();
    logic         exp_stall, acc;
    logic [W-1:0] rec;
    @(negedge clk);
    exp_stall = decodeValidIn && (src_blocked(sourceReg1In, sourceReg1ValidIn) ||
                                  src_blocked(sourceReg2In, sourceReg2ValidIn) ||
                                  (ref_out_valid && !readyIn));
    check("stall", W'(stallOut), W'(exp_stall));
    check("out_valid", W'(opcodeValidOut), W'(ref_out_valid));
    last_stall = stallOut;
    acc = decodeValidIn && !exp_stall && !reset;
    rec = {opcodeIn, sourceReg1In, sourceReg1ValidIn, ref_operand(sourceReg1In, sourceReg1ValidIn),
           sourceReg1ValidIn, sourceReg2In, sourceReg2ValidIn,
           ref_operand(sourceReg2In, sourceReg2ValidIn), sourceReg2ValidIn,
           destRegIn, destRegValidIn};
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (acc) begin
        exp_q.push_back(rec);
        ref_out_valid = 1'b1;
      end else if (readyIn) begin
        ref_out_valid = 1'b0;
      end
      if (wbValidIn) begin
        ref_regs[wbRegIn] = wbDataIn;
        ref_busy[wbRegIn] = 1'b0;
      end
      if (acc && destRegValidIn) ref_busy[destRegIn] = 1'b1;
    end
  endtask

  // Monitor: every downstream transfer must match the oldest expected instruction.
  always @(negedge clk) begin
    if (reset === 1'b0 && opcodeValidOut === 1'b1 && readyIn === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h expected none", out_vec());
      end else begin
        check("output", out_vec(), exp_q.pop_front());
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    readyIn = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    step();
    check("reset_outputs", out_vec(), '0);
    idle();

    // Writeback then read through the file.
    wb(4'd3, 64'hDEAD); step(); idle();
    issue(8'h11, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step(); idle();
    check("tp1_op1", W'(operand1ValOut), W'(64'hDEAD));
    check("tp1_op1_valid", W'(operand1ValValidOut), W'(1'b1));
    check("tp1_stall", W'(last_stall), W'(1'b0));

    // RAW on dest 5 stalls until the writeback cycle, which bypasses.
    issue(8'h21, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      issue(8'h22, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step();
      check("tp2_stall", W'(last_stall), W'(1'b1));
    end
    wb(4'd5, 64'h1234); step(); idle();
    check("tp2_release", W'(last_stall), W'(1'b0));
    check("tp2_bypass", W'(operand1ValOut), W'(64'h1234));
    issue(8'h23, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step(); idle();
    check("tp2_busy_clear", W'(last_stall), W'(1'b0));

    // Output held under backpressure, then replaced on the ready edge.
    issue(8'hA1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      readyIn = 1'b0;
      issue(8'hA2, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step();
      check("tp3_stall", W'(last_stall), W'(1'b1));
      check("tp3_hold", W'(opcodeOut), W'(8'hA1));
    end
    readyIn = 1'b1; step(); idle();
    check("tp3_load", W'(opcodeOut), W'(8'hA2));

    // Scoreboard set beats a same-edge writeback clear.
    issue(8'h71, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1); wb(4'd7, 64'h77); step(); idle();
    issue(8'h72, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step();
    check("tp4_set_wins", W'(last_stall), W'(1'b1));
    wb(4'd7, 64'h700); step(); idle();
    check("tp4_bypass", W'(operand1ValOut), W'(64'h700));

    // Back-to-back independent instructions.
    for (int i = 0; i < 8; i++) begin
      issue(8'h80 + 8'(i), 4'(i), 1'b1, 4'(15 - i), 1'b1, 4'd0, 1'b0); step();
      check("tp5_stall", W'(last_stall), W'(1'b0));
      check("tp5_opcode", W'(opcodeOut), W'(8'h80 + 8'(i)));
    end
    idle();

    // Mid-operation reset drops the in-flight instruction and all busy bits.
    wb(4'd2, 64'h2222); step(); idle();
    issue(8'h61, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1); step(); idle();
    reset = 1'b1; readyIn = 1'b0; step(); idle();
    check("tp6_reset_outputs", out_vec(), '0);
    check("tp6_reset_valid", W'(opcodeValidOut), W'(1'b0));
    issue(8'h62, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step(); idle();
    check("tp6_no_stall", W'(last_stall), W'(1'b0));
    check("tp6_op1_zero", W'(operand1ValOut), W'(64'd0));

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      decodeValidIn     = ($urandom_range(0, 3) != 0);
      opcodeIn          = 8'($urandom);
      sourceReg1In      = 4'($urandom_range(0, 15));
      sourceReg2In      = 4'($urandom_range(0, 15));
      sourceReg1ValidIn = 1'($urandom_range(0, 1));
      sourceReg2ValidIn = 1'($urandom_range(0, 1));
      destRegIn         = 4'($urandom_range(0, 15));
      destRegValidIn    = 1'($urandom_range(0, 1));
      wbValidIn         = 1'($urandom_range(0, 1));
      wbRegIn           = 4'($urandom_range(0, 15));
      wbDataIn          = {$urandom, $urandom};
      readyIn           = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        reset   = 1'b1;
        readyIn = 1'b0;
      end
      step();
    end

    idle();
    for (int i = 0; i < 3; i++) step();
    check("drain_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_read_stage.md
# register_read_stage

Pipeline stage directly upstream of address calculation. It accepts one decoded instruction per cycle, checks a per-register busy scoreboard, and reads both source operands from a 16 x 64-bit architectural register file, bypassing same-cycle writeback. It presents the result in a one-entry output register that feeds the address-calculation stage. Writeback into the register file and scoreboard release come from the end of the pipeline.

## Interface
Parameters:
- NUM_REGS, 16, number of architectural registers (index width 4)
- DATA_W, 64, register and operand width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- decodeValidIn  in  1  decoded instruction present this cycle
- opcodeIn  in  8  opcode, carried through unchanged
- sourceReg1In / sourceReg2In  in  4 each  source register indices
- sourceReg1ValidIn / sourceReg2ValidIn  in  1 each  source is used
- destRegIn  in  4  destination register index
- destRegValidIn  in  1  instruction writes destRegIn
- stallOut  out  1  decode must hold its instruction (combinational)
- wbValidIn  in  1  writeback this cycle
- wbRegIn  in  4  writeback register index
- wbDataIn  in  64  writeback data
- readyIn  in  1  address calculation can take the output register this cycle
- opcodeValidOut  out  1  output register holds a valid instruction
- opcodeOut  out  8  latched opcode
- sourceRegCode1Out / sourceRegCode2Out  out  4 each  latched source indices
- sourceRegCode1ValidOut / sourceRegCode2ValidOut  out  1 each  latched source-used flags
- operand1ValOut / operand2ValOut  out  64 each  latched operand values
- operand1ValValidOut / operand2ValValidOut  out  1 each  operand is meaningful (equals the source-used flag)
- destRegOut  out  4  latched destination
- destRegValidOut  out  1  latched destination-used flag

## Operation
- State:
  - regfile[16] x 64
  - busy[16]
  - output register: all *Out fields except stallOut
- hazard:
  - Raised when a valid source s has busy[s]=1, unless wbValidIn && wbRegIn==s in the same cycle.
  - A same-cycle writeback clears the hazard for that source.
- outBlocked = opcodeValidOut && !readyIn.
- stallOut = decodeValidIn && (hazard || outBlocked). Combinational, same cycle.
- accept = decodeValidIn && !stallOut.
- Operand read: if wbValidIn && wbRegIn==src, the operand is wbDataIn (bypass). Otherwise it is regfile[src]. An unused source latches 0 and its Valid flag is 0.
- Output register update, per edge:
  - accept: load all fields, opcodeValidOut <= 1.
  - else if readyIn: opcodeValidOut <= 0. Other fields hold their last values.
  - else: hold everything.
- Writeback: wbValidIn writes regfile[wbRegIn] <= wbDataIn and clears busy[wbRegIn].
- Scoreboard set: accept && destRegValidIn sets busy[destRegIn].
  - If the same edge also clears that register via writeback, the set wins (the new producer owns it).
- There is no special zero register; all 16 entries are writable.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N with opcodeValidOut=1.
- Throughput: 1 per cycle while readyIn=1 and there are no hazards.
- Handshake: the output transfers on any edge with opcodeValidOut && readyIn. When readyIn and accept coincide, the new instruction replaces the old one with no bubble.
- RAW dependency on the previous instruction: stalls until writeback. In the writeback cycle the instruction is accepted via the bypass.
- Reset (synchronous, evaluated at the edge):
  - regfile all 0, busy all 0
  - opcodeValidOut=0 and every other *Out register cleared to 0
  - stallOut is combinational, so it is 0 during reset unless inputs force it
  - reset overrides a same-edge accept or writeback
- Mid-operation reset: the in-flight output instruction is discarded and all busy bits are cleared.

## Test plan
- Reset, then wbValidIn=1, wbRegIn=3, wbDataIn=0xDEAD; next cycle issue src1=3, no dest, readyIn=1 -> after 1 cycle operand1ValOut=0xDEAD, operand1ValValidOut=1, opcodeValidOut=1, stallOut=0.
- Issue dest=5 (accepted), then src1=5 -> stallOut=1 every cycle. Then wbRegIn=5, wbDataIn=0x1234 -> stallOut=0 that cycle, operand1ValOut=0x1234 next cycle, busy[5]=0.
- Hold readyIn=0 with a valid output and a new decodeValidIn=1 -> stallOut=1 and outputs unchanged for 3 cycles. Raise readyIn=1 -> new instruction loads the same edge.
- Same edge: accept with dest=7 and wbValidIn, wbRegIn=7 -> busy[7]=1 afterwards; a following src1=7 stalls.
- Back-to-back independent instructions with readyIn=1 for 8 cycles -> opcodeValidOut=1 each cycle, opcodes in order, no stall.
- Set busy[2], hold a valid output, assert reset for 1 cycle -> opcodeValidOut=0, all outputs 0, and a subsequent src1=2 is accepted without stall reading 0.
